op_buffer_ctrl: RTL and testbench

Controller that sequences the 16-entry, 32-bit output buffer between the systolic array result stream and the external read port. It accepts array results through a valid/ready handshake and writes them into the buffer in circular FIFO order. On an external burst request it issues buffer read commands in the same order and flags each word as it appears on the buffer's registered output. It owns the buffer's store/send instruction strobes and both address buses; the buffer itself stays a plain storage array.

---
 rtl/op_buffer_ctrl.sv | 92 +++++++++
 tb/tb_op_buffer_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/op_buffer_ctrl.sv
// Output-buffer sequencer: writes array results into a 16-entry circular buffer
// and replays them in FIFO order as bursts toward the external read port.
module op_buffer_ctrl #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  output logic              st_en,
  output logic [ADDR_W-1:0] st_addr,
  output logic [DATA_W-1:0] st_data,
  output logic              sd_en,
  output logic [ADDR_W-1:0] sd_addr,
  input  logic              ext_req,
  input  logic [4:0]        ext_len,
  input  logic              ext_ready,
  output logic              ext_valid,
  output logic              burst_done,
  output logic [4:0]        count,
  output logic              full,
  output logic              empty,
  output logic              busy
);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [4:0]        remaining;
  logic [4:0]        burst_len;
  logic              req_accept;
  logic              last_send;

  assign full       = (count == 5'(DEPTH));
  assign empty      = (count == 5'd0);
  assign burst_len  = (ext_len > 5'(DEPTH)) ? 5'(DEPTH) : ext_len;
  assign req_accept = (state == IDLE) && ext_req && (ext_len != 5'd0) && !clear;
  assign last_send  = sd_en && (remaining == 5'd1);
  assign st_addr    = wr_ptr;
  assign st_data    = res_data;
  assign sd_addr    = rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ext_req && ext_len != 5'd0) state_nxt = DRAIN;
      DRAIN:   if (last_send) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Sends are gated by rst as well so nothing leaves the buffer during reset.
  always_comb begin
    res_ready = rst && !clear && !full;
    st_en     = res_valid && res_ready;
    sd_en     = rst && (state == DRAIN) && ext_ready && !empty && !clear;
    busy      = (state == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      remaining  <= '0;
      ext_valid  <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      if (st_en) wr_ptr <= wr_ptr + 1'b1;
      if (sd_en) rd_ptr <= rd_ptr + 1'b1;
      if (st_en && !sd_en)      count <= count + 5'd1;
      else if (sd_en && !st_en) count <= count - 5'd1;
      if (req_accept)  remaining <= burst_len;
      else if (sd_en)  remaining <= remaining - 5'd1;
      // The buffer output register is loaded by sd_en, so its valid trails by one.
      ext_valid  <= sd_en;
      burst_done <= last_send;
    end
  end

endmodule

// File: tb/tb_op_buffer_ctrl.sv
// Randomized bench for op_buffer_ctrl against a queue-based FIFO/burst model,
// with a small storage array standing in for the output buffer.
module tb_op_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst, clear, res_valid, ext_req, ext_ready;
  logic [31:0] res_data;
  logic [4:0]  ext_len;
  logic        res_ready, st_en, sd_en, ext_valid, burst_done, full, empty, busy;
  logic [3:0]  st_addr, sd_addr;
  logic [31:0] st_data;
  logic [4:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  op_buffer_ctrl #(.DEPTH(16), .ADDR_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .st_en(st_en), .st_addr(st_addr), .st_data(st_data),
    .sd_en(sd_en), .sd_addr(sd_addr),
    .ext_req(ext_req), .ext_len(ext_len), .ext_ready(ext_ready),
    .ext_valid(ext_valid), .burst_done(burst_done),
    .count(count), .full(full), .empty(empty), .busy(busy)
  );

  always #5 clk = ~clk;

  // Plain storage array with a registered read port.
  logic [31:0] bmem [16];
  logic [31:0] bout;
  always @(posedge clk) begin
    if (st_en) bmem[st_addr] <= st_data;
    if (sd_en) bout <= bmem[sd_addr];
  end

  // Reference model state.
  logic [31:0] q[$];
  int          m_wr, m_rd, m_rem;
  bit          m_drain, m_ev, m_bd, m_known;
  logic [31:0] m_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input bit v, input logic [31:0] d, input bit req,
                        input logic [4:0] len, input bit rdy);
    res_valid = v; res_data = d; ext_req = req; ext_len = len; ext_ready = rdy;
  endtask

  task automatic cycle();
    bit exp_ready, exp_st, exp_sd, was_drain;
    int len;
    @(negedge clk);
    exp_ready = rst && !clear && (q.size() < 16);
    exp_st    = res_valid && exp_ready;
    exp_sd    = rst && !clear && m_drain && ext_ready && (q.size() > 0);
    if (m_known) begin
      check("res_ready", 32'(res_ready), 32'(exp_ready));
      check("st_en", 32'(st_en), 32'(exp_st));
      check("sd_en", 32'(sd_en), 32'(exp_sd));
      check("count", 32'(count), 32'(q.size()));
      check("full", 32'(full), 32'(q.size() == 16));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("busy", 32'(busy), 32'(m_drain));
      check("ext_valid", 32'(ext_valid), 32'(m_ev));
      check("burst_done", 32'(burst_done), 32'(m_bd));
      if (exp_st) begin
        check("st_addr", 32'(st_addr), 32'(m_wr));
        check("st_data", st_data, res_data);
      end
      if (exp_sd) check("sd_addr", 32'(sd_addr), 32'(m_rd));
      if (m_ev)   check("ext_word", bout, m_word);
    end
    if (!rst || clear) begin
      q.delete(); m_wr = 0; m_rd = 0; m_rem = 0;
      m_drain = 0; m_ev = 0; m_bd = 0;
    end else begin
      was_drain = m_drain;
      m_ev = exp_sd;
      m_bd = 0;
      if (exp_sd) begin
        m_word = q.pop_front();
        m_rd   = (m_rd + 1) % 16;
        m_rem--;
        if (m_rem == 0) begin m_bd = 1; m_drain = 0; end
      end
      if (exp_st) begin
        q.push_back(res_data);
        m_wr = (m_wr + 1) % 16;
      end
      len = int'(ext_len);
      if (!was_drain && ext_req && len != 0) begin
        m_drain = 1;
        m_rem   = (len > 16) ? 16 : len;
      end
    end
    @(posedge clk);
    #1;
    m_known = 1;
  endtask

  initial begin
    m_known = 0; m_drain = 0; m_ev = 0; m_bd = 0; m_word = '0;
    m_wr = 0; m_rd = 0; m_rem = 0;
    rst = 1'b0; clear = 1'b0;
    set_in(0, '0, 0, '0, 0);
    repeat (3) cycle();
    rst = 1'b1;

    // Fill with 0xA0..0xAF plus a 17th word that must be refused.
    for (int i = 0; i < 17; i++) begin
      set_in(1, 32'hA0 + 32'(i), 0, '0, 0);
      cycle();
    end
    check("fill_count", 32'(count), 32'd16);

    // Burst of 4 from a full buffer.
    set_in(0, '0, 1, 5'd4, 1); cycle();
    set_in(0, '0, 0, 5'd0, 1); repeat (6) cycle();
    check("after_burst4", 32'(count), 32'd12);

    // Concurrent store and send with clamped bursts; pointers wrap.
    for (int i = 0; i < 40; i++) begin
      set_in(1, 32'hB000 + 32'(i), 1, 5'd31, 1);
      cycle();
    end
    set_in(0, '0, 0, 5'd0, 1); repeat (20) cycle();

    // ext_len=0 is ignored; ext_len=20 clamps to 16.
    set_in(0, '0, 1, 5'd0, 1); cycle();
    check("len0_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 16; i++) begin set_in(1, 32'hC0 + 32'(i), 0, 5'd0, 0); cycle(); end
    set_in(0, '0, 1, 5'd20, 1); cycle();
    set_in(0, '0, 0, 5'd0, 1); repeat (20) cycle();

    // Stall and backpressure: 2 words, burst of 5, toggled ready, late stores.
    clear = 1'b1; cycle(); clear = 1'b0;
    for (int i = 0; i < 2; i++) begin set_in(1, 32'hD0 + 32'(i), 0, 5'd0, 0); cycle(); end
    set_in(0, '0, 1, 5'd5, 1); cycle();
    set_in(0, '0, 0, 5'd0, 1); cycle();
    set_in(0, '0, 0, 5'd0, 0); cycle();
    set_in(0, '0, 0, 5'd0, 1); repeat (4) cycle();
    check("stall_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin set_in(1, 32'hD2 + 32'(i), 0, 5'd0, 1); cycle(); end
    set_in(0, '0, 0, 5'd0, 1); repeat (4) cycle();

    // Full with a pending send, then clear and reset in mid-burst.
    for (int i = 0; i < 18; i++) begin set_in(1, 32'hE0 + 32'(i), 0, 5'd0, 0); cycle(); end
    set_in(1, 32'hEE, 1, 5'd16, 1); repeat (3) cycle();
    clear = 1'b1; cycle(); clear = 1'b0;
    set_in(0, '0, 0, 5'd0, 1); repeat (2) cycle();
    for (int i = 0; i < 6; i++) begin set_in(1, 32'hF0 + 32'(i), 0, 5'd0, 0); cycle(); end
    set_in(0, '0, 1, 5'd6, 1); repeat (3) cycle();
    rst = 1'b0; cycle(); rst = 1'b1;
    repeat (2) cycle();

    // Randomized traffic with occasional clear and reset.
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 30,
             5'($urandom_range(0, 31)), $urandom_range(0, 99) < 70);
      clear = ($urandom_range(0, 199) == 0);
      rst   = ($urandom_range(0, 399) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
